wishbus_dma_master: RTL and testbench

Single-channel DMA master on the user side of the 4-port wishbus arbiter. It converts a command (direction, base address, word count) into a sequence of single-word wishbus transfers against a RAM bridge. It streams write data in from, or read data out to, an 8-deep internal FIFO with valid/ready handshakes. It owns the bus from grant until the last word completes, then releases it.

---
 rtl/wishbus_dma_master.sv | 214 +++++++++++++++++++++
 tb/tb_wishbus_dma_master.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbus_dma_master.sv
// rtl/wishbus_dma_master.sv - single-channel wishbus DMA master with internal stream FIFO
//
// Converts one command (direction, first word address, word count) into single-word
// wishbus transfers. It holds bus ownership from grant until the last word completes.
// Write data streams in through wr_*. Read data streams out through rd_*.
// Both streams share one FIFO whose direction follows the latched command.
//
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready               command handshake (ready only in IDLE)
//   cmd_read, cmd_addr, cmd_len       1 = memory->stream; first word address; word count 0..2^ADDR_W
//   wr_valid/wr_ready/wr_data         write-stream input into the FIFO
//   rd_valid/rd_ready/rd_data         read-stream output from the FIFO
//   busy, done                        command in progress; one-cycle completion pulse
//   bus_rst_i                         tied low
//   bus_addr_i, bus_dat_o, bus_we_i   transfer address, write data, direction (1 = read)
//   bus_stb_i                         one-cycle transfer strobe
//   bus_sel_i                         active-low ownership request
//   bus_dat_i, bus_cyc_o, bus_stb_o   device read data and device busy flags
//   bus_ack_o                         arbiter grant
module wishbus_dma_master #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_read,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              bus_rst_i,
    output logic [ADDR_W-1:0] bus_addr_i,
    output logic [DATA_W-1:0] bus_dat_o,
    output logic              bus_we_i,
    output logic              bus_stb_i,
    output logic              bus_sel_i,
    input  logic [DATA_W-1:0] bus_dat_i,
    input  logic              bus_cyc_o,
    input  logic              bus_stb_o,
    input  logic              bus_ack_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]     FULL_CNT = (PW+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0] ONE_WORD = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_ISSUE, S_WAIT_START, S_WAIT_END, S_RELEASE, S_FINISH
    } state_t;

    state_t state, state_next;

    logic              dir_read;
    logic [ADDR_W-1:0] addr_cur;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   wr_accepted;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wptr, rptr;
    logic [PW:0]       count;

    logic              busy_q, done_q, sel_q, stb_q, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dat_q;

    logic accept, issue, complete, finish_ok, own_next;
    logic fifo_empty, fifo_full, dev_idle;
    logic wr_hs, rd_hs, push, pop;
    logic [DATA_W-1:0] push_data;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign dev_idle   = !bus_cyc_o && !bus_stb_o;

    // Stream sides are gated by the latched direction so the shared buffer never
    // leaks write data to the read port or accepts more words than the command needs.
    assign wr_ready  = busy_q && !dir_read && !fifo_full && (wr_accepted != len_q);
    assign rd_valid  = dir_read && !fifo_empty;
    assign rd_data   = mem[rptr];
    assign cmd_ready = (state == S_IDLE);
    assign busy      = busy_q;
    assign done      = done_q;

    assign bus_rst_i  = 1'b0;
    assign bus_addr_i = addr_q;
    assign bus_dat_o  = dat_q;
    assign bus_we_i   = we_q;
    assign bus_stb_i  = stb_q;
    assign bus_sel_i  = sel_q;

    assign wr_hs     = wr_valid && wr_ready;
    assign rd_hs     = rd_valid && rd_ready;
    assign push      = wr_hs || (complete && dir_read);
    assign pop       = rd_hs || (complete && !dir_read);
    assign push_data = dir_read ? bus_dat_i : wr_data;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issue      = 1'b0;
        complete   = 1'b0;
        finish_ok  = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    accept     = 1'b1;
                    state_next = (cmd_len == '0) ? S_FINISH : S_REQ;
                end
            end
            S_REQ: begin
                if (bus_ack_o) state_next = S_ISSUE;
            end
            S_ISSUE: begin
                // A read reserves its FIFO slot here; only one word is ever in flight.
                if (dev_idle && (dir_read ? !fifo_full : !fifo_empty)) begin
                    issue      = 1'b1;
                    state_next = S_WAIT_START;
                end
            end
            S_WAIT_START: begin
                if (bus_cyc_o) state_next = S_WAIT_END;
            end
            S_WAIT_END: begin
                if (!bus_cyc_o) begin
                    complete   = 1'b1;
                    state_next = (remaining == ONE_WORD) ? S_RELEASE : S_ISSUE;
                end
            end
            S_RELEASE: state_next = S_FINISH;
            S_FINISH: begin
                if (!rd_valid) begin
                    finish_ok  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Ownership is held across all words so the arbiter never re-arbitrates mid-command.
    assign own_next = (state_next == S_REQ) || (state_next == S_ISSUE) ||
                      (state_next == S_WAIT_START) || (state_next == S_WAIT_END);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dir_read    <= 1'b0;
            addr_cur    <= '0;
            remaining   <= '0;
            len_q       <= '0;
            wr_accepted <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sel_q       <= 1'b1;
            stb_q       <= 1'b0;
            we_q        <= 1'b1;
            addr_q      <= '0;
            dat_q       <= '0;
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_hs) wr_accepted <= wr_accepted + 1'b1;
            if (accept) begin
                dir_read    <= cmd_read;
                addr_cur    <= cmd_addr;
                remaining   <= cmd_len;
                len_q       <= cmd_len;
                wr_accepted <= '0;
            end
            if (complete) begin
                addr_cur  <= addr_cur + 1'b1;
                remaining <= remaining - 1'b1;
            end
            if (issue) begin
                addr_q <= addr_cur;
                we_q   <= dir_read;
                if (!dir_read) dat_q <= mem[rptr];
            end
            stb_q  <= issue;
            sel_q  <= !own_next;
            done_q <= finish_ok;
            // busy drops the cycle after the done pulse unless a new command lands then.
            if (accept)      busy_q <= 1'b1;
            else if (done_q) busy_q <= 1'b0;

            if (push) begin
                mem[wptr] <= push_data;
                wptr      <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_wishbus_dma_master.sv
// tb/tb_wishbus_dma_master.sv - scoreboard bench for wishbus_dma_master with RAM bridge model
module tb_wishbus_dma_master;
    localparam int AW = 10;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dev_rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          cmd_valid, cmd_ready, cmd_read;
    logic [AW-1:0] cmd_addr;
    logic [AW:0]   cmd_len;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid, rd_ready;
    logic [DW-1:0] rd_data;
    logic          busy, done;
    logic          bus_rst_i, bus_we_i, bus_stb_i, bus_sel_i;
    logic [AW-1:0] bus_addr_i;
    logic [DW-1:0] bus_dat_o;
    logic [DW-1:0] bus_dat_i;
    logic          bus_cyc_o, bus_stb_o, bus_ack_o;

    assign bus_stb_o = 1'b0;

    wishbus_dma_master #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(8)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done),
        .bus_rst_i(bus_rst_i), .bus_addr_i(bus_addr_i), .bus_dat_o(bus_dat_o),
        .bus_we_i(bus_we_i), .bus_stb_i(bus_stb_i), .bus_sel_i(bus_sel_i),
        .bus_dat_i(bus_dat_i), .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o),
        .bus_ack_o(bus_ack_o)
    );

    function automatic logic [15:0] seed_word(input int i);
        return 16'(i * 37 + 4660);
    endfunction

    // RAM bridge + arbiter: grant one cycle after request; stb -> cyc up (+1) -> cyc down (+3).
    logic [DW-1:0] dev_ram [1024];
    logic [1:0]    dev_cnt;
    logic [AW-1:0] dev_addr;
    logic          dev_we, dev_owner;
    logic [DW-1:0] dev_wdat;

    always @(posedge clk) begin
        if (!dev_rst_n) begin
            for (int i = 0; i < 1024; i++) dev_ram[i] <= seed_word(i);
            bus_cyc_o <= 1'b0; bus_ack_o <= 1'b0; bus_dat_i <= 16'hDEAD;
            dev_cnt <= '0; dev_addr <= '0; dev_we <= 1'b0; dev_wdat <= '0; dev_owner <= 1'b0;
        end else begin
            bus_dat_i <= 16'hDEAD;
            bus_ack_o <= !bus_sel_i && !dev_owner;
            dev_owner <= !bus_sel_i;
            if (dev_cnt != 0) begin
                dev_cnt <= dev_cnt - 1'b1;
                if (dev_cnt == 2'd1) begin
                    bus_cyc_o <= 1'b0;
                    if (dev_we) bus_dat_i <= dev_ram[dev_addr];
                    else        dev_ram[dev_addr] <= dev_wdat;
                end
            end else if (bus_stb_i) begin
                bus_cyc_o <= 1'b1; dev_cnt <= 2'd3;
                dev_addr <= bus_addr_i; dev_we <= bus_we_i; dev_wdat <= bus_dat_o;
            end
        end
    end

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] dat;
    } xfer_t;

    xfer_t         exp_bus_q[$];
    logic [DW-1:0] exp_rd_q[$];
    logic [DW-1:0] feed_q[$];
    logic [DW-1:0] ref_ram [1024];

    int  vectors = 0;
    int  miscompares = 0;
    int  stb_cnt = 0;
    int  done_cnt = 0;
    bit  feed_en = 1'b1;
    bit  rd_hold = 1'b0;
    bit  rd_rand = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        xfer_t x;
        logic [DW-1:0] d;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus_stb_i) begin
                    stb_cnt++;
                    chk("stb_while_dev_busy", {31'd0, bus_cyc_o | bus_stb_o}, 32'd0);
                    chk("stb_without_ownership", {31'd0, bus_sel_i}, 32'd0);
                    if (exp_bus_q.size() == 0) fail("unexpected_stb");
                    else begin
                        x = exp_bus_q.pop_front();
                        chk("bus_addr", {22'd0, bus_addr_i}, {22'd0, x.addr});
                        chk("bus_we", {31'd0, bus_we_i}, {31'd0, x.we});
                        if (!x.we) chk("bus_dat", {16'd0, bus_dat_o}, {16'd0, x.dat});
                    end
                end
                if (rd_valid && rd_ready) begin
                    if (exp_rd_q.size() == 0) fail("unexpected_rd_word");
                    else begin
                        d = exp_rd_q.pop_front();
                        chk("rd_data", {16'd0, rd_data}, {16'd0, d});
                    end
                end
                if (done) begin
                    done_cnt++;
                    chk("rd_drained_at_done", exp_rd_q.size(), 32'd0);
                end
            end
        end
    endtask

    task automatic feeder();
        bit hs;
        wr_valid = 1'b0;
        wr_data  = '0;
        forever begin
            @(negedge clk);
            hs = wr_valid && wr_ready;
            @(posedge clk);
            #1;
            if (hs && feed_q.size() > 0) void'(feed_q.pop_front());
            if (!feed_en || feed_q.size() == 0) wr_valid = 1'b0;
            else if (wr_valid && !hs) wr_data = feed_q[0];
            else if (!rd_rand || $urandom_range(3) != 0) begin
                wr_valid = 1'b1;
                wr_data  = feed_q[0];
            end else wr_valid = 1'b0;
        end
    endtask

    task automatic consumer();
        forever begin
            @(posedge clk);
            #1;
            rd_ready = rd_hold ? 1'b0 : (rd_rand ? 1'($urandom_range(1)) : 1'b1);
        end
    endtask

    // Reference: word i of a command hits address (addr + i) mod 1024; reads return the
    // last data written there, writes consume the stream in order.
    task automatic run_cmd(input bit rd, input logic [AW-1:0] a, input int n, input int base);
        logic [AW-1:0] ad;
        logic [DW-1:0] d;
        int guard;
        for (int i = 0; i < n; i++) begin
            ad = AW'(int'(a) + i);
            if (rd) begin
                exp_bus_q.push_back('{addr: ad, we: 1'b1, dat: 16'h0});
                exp_rd_q.push_back(ref_ram[ad]);
            end else begin
                d = (base >= 0) ? 16'(base + i) : 16'($urandom);
                exp_bus_q.push_back('{addr: ad, we: 1'b0, dat: d});
                feed_q.push_back(d);
                ref_ram[ad] = d;
            end
        end
        guard = 0;
        while (!cmd_ready && guard < 200) begin tick(); guard++; end
        if (!cmd_ready) fail("cmd_ready_timeout");
        cmd_valid = 1'b1; cmd_read = rd; cmd_addr = a; cmd_len = (AW+1)'(n);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic finish_cmd(input string name, input int d0);
        int guard;
        guard = 0;
        while (done_cnt == d0 && guard < 3000) begin tick(); guard++; end
        if (done_cnt == d0) fail({name, "_done_timeout"});
        repeat (3) tick();
        chk({name, "_done_once"}, done_cnt - d0, 32'd1);
        chk({name, "_bus_left"}, exp_bus_q.size(), 32'd0);
        chk({name, "_sel_released"}, {31'd0, bus_sel_i}, 32'd1);
        chk({name, "_busy_low"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int d0, s0, guard;
        logic [DW-1:0] keep2, keep3;
        cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0; cmd_len = '0; rd_ready = 1'b0;
        for (int i = 0; i < 1024; i++) ref_ram[i] = seed_word(i);
        fork
            monitor();
            feeder();
            consumer();
        join_none

        repeat (3) tick();
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sel", {31'd0, bus_sel_i}, 32'd1);
        chk("rst_stb", {31'd0, bus_stb_i}, 32'd0);
        chk("rst_we", {31'd0, bus_we_i}, 32'd1);
        chk("rst_addr", {22'd0, bus_addr_i}, 32'd0);
        chk("rst_dat_o", {16'd0, bus_dat_o}, 32'd0);
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
        chk("rst_bus_rst", {31'd0, bus_rst_i}, 32'd0);
        dev_rst_n = 1'b1;
        rst_n = 1'b1;
        repeat (2) tick();

        // Write burst with two surplus stream words that must stay unaccepted.
        d0 = done_cnt;
        run_cmd(1'b0, 10'h010, 4, 16'hA000);
        feed_q.push_back(16'hBEEF);
        feed_q.push_back(16'hBEF0);
        finish_cmd("wr_burst", d0);
        chk("wr_surplus_not_taken", feed_q.size(), 32'd2);
        feed_q.delete();
        for (int i = 0; i < 4; i++)
            chk("wr_burst_ram", {16'd0, dev_ram[10'h010 + i]}, 32'hA000 + i);

        d0 = done_cnt;
        run_cmd(1'b1, 10'h010, 4, -1);
        finish_cmd("rd_burst", d0);

        d0 = done_cnt;
        run_cmd(1'b0, 10'h3FE, 4, 16'h5000);
        finish_cmd("addr_wrap", d0);

        // Read backpressure: FIFO fills after 8 words, master holds the bus in ISSUE.
        rd_hold = 1'b1;
        d0 = done_cnt; s0 = stb_cnt;
        run_cmd(1'b1, 10'h3F8, 12, -1);
        repeat (150) tick();
        chk("bp_transfers", stb_cnt - s0, 32'd8);
        chk("bp_sel_held", {31'd0, bus_sel_i}, 32'd0);
        chk("bp_rd_valid", {31'd0, rd_valid}, 32'd1);
        rd_hold = 1'b0;
        finish_cmd("bp", d0);

        // Zero length: done two cycles after accept, no bus activity.
        d0 = done_cnt; s0 = stb_cnt;
        run_cmd(1'b0, 10'h055, 0, -1);
        chk("len0_done_c1", {31'd0, done}, 32'd0);
        chk("len0_sel_c1", {31'd0, bus_sel_i}, 32'd1);
        tick();
        chk("len0_done_c2", {31'd0, done}, 32'd1);
        chk("len0_sel_c2", {31'd0, bus_sel_i}, 32'd1);
        tick();
        chk("len0_done_c3", {31'd0, done}, 32'd0);
        chk("len0_busy_c3", {31'd0, busy}, 32'd0);
        repeat (3) tick();
        chk("len0_no_stb", stb_cnt - s0, 32'd0);
        chk("len0_done_once", done_cnt - d0, 32'd1);

        // Write underflow: stream idle stalls in ISSUE with ownership held.
        feed_en = 1'b0;
        d0 = done_cnt; s0 = stb_cnt;
        run_cmd(1'b0, 10'h100, 3, -1);
        repeat (40) tick();
        chk("uf_no_stb", stb_cnt - s0, 32'd0);
        chk("uf_sel_held", {31'd0, bus_sel_i}, 32'd0);
        feed_en = 1'b1;
        finish_cmd("uf", d0);

        // Reset while word 2 of 4 is in WAIT_END; the bridge still finishes that word.
        keep2 = ref_ram[10'h202];
        keep3 = ref_ram[10'h203];
        s0 = stb_cnt;
        run_cmd(1'b0, 10'h200, 4, 16'h7700);
        ref_ram[10'h202] = keep2;
        ref_ram[10'h203] = keep3;
        guard = 0;
        while (stb_cnt - s0 < 2 && guard < 200) begin tick(); guard++; end
        if (stb_cnt - s0 < 2) fail("rst_mid_word2_timeout");
        guard = 0;
        while (!bus_cyc_o && guard < 20) begin tick(); guard++; end
        tick();
        chk("rst_mid_in_wait_end", {31'd0, bus_cyc_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_sel", {31'd0, bus_sel_i}, 32'd1);
        chk("rst_mid_stb", {31'd0, bus_stb_i}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_wr_ready", {31'd0, wr_ready}, 32'd0);
        exp_bus_q.delete();
        feed_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        d0 = done_cnt;
        run_cmd(1'b0, 10'h210, 1, 16'h6161);
        finish_cmd("post_rst_len1", d0);
        d0 = done_cnt;
        run_cmd(1'b1, 10'h200, 4, -1);
        finish_cmd("post_rst_readback", d0);

        // Randomized commands with random stream gaps and read backpressure.
        rd_rand = 1'b1;
        for (int k = 0; k < 16; k++) begin
            d0 = done_cnt;
            run_cmd(1'($urandom_range(1)), AW'($urandom_range(1023)), $urandom_range(1, 12), -1);
            finish_cmd("rand", d0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
